// File: rtl/tcb_pkg.sv
// Shared TCB definitions: default bus widths and request/response records
// used by every tcb_lib block.
package tcb_pkg;

  localparam int TCB_ABW = 32;
  localparam int TCB_DBW = 32;
  localparam int TCB_SLW = 8;
  localparam int TCB_BEW = TCB_DBW / TCB_SLW;

  typedef struct packed {
    logic               wen;
    logic [TCB_ABW-1:0] adr;
    logic [TCB_BEW-1:0] ben;
    logic [TCB_DBW-1:0] wdt;
  } tcb_req_t;

  typedef struct packed {
    logic [TCB_DBW-1:0] rdt;
    logic               err;
  } tcb_rsp_t;

  // Number of read-data hold groups for a given byte-enable width
  function automatic int tcb_grp_cnt(input int bew, input int grn);
    return bew / grn;
  endfunction

endpackage

// File: rtl/tcb_lib_register_response_if.sv
// TCB bus bundle. Handshake: a transfer happens in every cycle where vld and
// rdy are both high; vld=1 with rdy=0 is a stall, and rdt/err follow later.
interface tcb_lib_register_response_if
  import tcb_pkg::*;
#(
  parameter int ABW = TCB_ABW,
  parameter int DBW = TCB_DBW,
  parameter int SLW = TCB_SLW
);
  localparam int BEW = DBW / SLW;

  logic           vld;
  logic           wen;
  logic [ABW-1:0] adr;
  logic [BEW-1:0] ben;
  logic [DBW-1:0] wdt;
  logic           rdy;
  logic [DBW-1:0] rdt;
  logic           err;

  modport master (output vld, wen, adr, ben, wdt, input rdy, rdt, err);
  modport slave  (input vld, wen, adr, ben, wdt, output rdy, rdt, err);

endinterface

// File: rtl/tcb_lib_delay_line.sv
// DLY-deep shift register of {trn, wen, ben}; the tap is the value from DLY
// cycles ago (combinational pass-through when DLY is 0).
module tcb_lib_delay_line #(
  parameter int DLY = 1,
  parameter int BEW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           trn,
  input  logic           wen,
  input  logic [BEW-1:0] ben,
  output logic           tap_trn,
  output logic           tap_wen,
  output logic [BEW-1:0] tap_ben
);

  localparam int W = BEW + 2;

  generate
    if (DLY == 0) begin : g_bypass
      assign {tap_trn, tap_wen, tap_ben} = {trn, wen, ben};
    end else begin : g_pipe
      logic [W-1:0] stage_q [DLY];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < DLY; k++) stage_q[k] <= '0;
        end else begin
          stage_q[0] <= {trn, wen, ben};
          for (int k = 1; k < DLY; k++) stage_q[k] <= stage_q[k-1];
        end
      end

      assign {tap_trn, tap_wen, tap_ben} = stage_q[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/tcb_lib_register_response.sv
// TCB register slice: request path passes straight through, the response
// (rdt, err) gains one register stage so the manager sees DLY+1 latency.
module tcb_lib_register_response
  import tcb_pkg::*;
#(
  parameter int ABW = TCB_ABW,
  parameter int DBW = TCB_DBW,
  parameter int SLW = TCB_SLW,
  parameter int BEW = DBW / SLW,
  parameter int DLY = 1,
  parameter int GRN = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  tcb_lib_register_response_if.slave  sub,
  tcb_lib_register_response_if.master man
);

  localparam int NGRP = tcb_grp_cnt(BEW, GRN);
  localparam int GW   = GRN * SLW;

  logic           trn;
  logic           tap_trn;
  logic           tap_wen;
  logic [BEW-1:0] tap_ben;
  logic [NGRP-1:0] grp_ld;
  logic [DBW-1:0] rdt_q;
  logic           err_q;

  assign man.vld = sub.vld;
  assign man.wen = sub.wen;
  assign man.adr = sub.adr[ABW-1:0];
  assign man.ben = sub.ben;
  assign man.wdt = sub.wdt;
  assign sub.rdy = man.rdy;

  assign trn = sub.vld & man.rdy;

  tcb_lib_delay_line #(
    .DLY (DLY),
    .BEW (BEW)
  ) u_delay_line (
    .clk     (clk),
    .rst     (rst),
    .trn     (trn),
    .wen     (sub.wen),
    .ben     (sub.ben),
    .tap_trn (tap_trn),
    .tap_wen (tap_wen),
    .tap_ben (tap_ben)
  );

  // A group of GRN bytes is reloaded when any of its byte enables was set on
  // the read whose data is arriving now; all other groups keep old data.
  always_comb begin
    grp_ld = '0;
    if (tap_trn && !tap_wen) begin
      for (int g = 0; g < NGRP; g++) grp_ld[g] = |tap_ben[g*GRN +: GRN];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (tap_trn) err_q <= man.err;
      for (int g = 0; g < NGRP; g++) begin
        if (grp_ld[g]) rdt_q[g*GW +: GW] <= man.rdt[g*GW +: GW];
      end
    end
  end

  assign sub.rdt = rdt_q;
  assign sub.err = err_q;

endmodule

// File: tb/tb_tcb_lib_register_response.sv
// Bench for tcb_lib_register_response: two slices (GRN=1, GRN=2, DLY=1) fed
// the same traffic and compared against a queue-based response model.
module tb_tcb_lib_register_response;

  localparam int ABW = 32;
  localparam int DBW = 32;
  localparam int SLW = 8;
  localparam int BEW = DBW / SLW;
  localparam int DLY = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic           t_vld = 1'b0;
  logic           t_wen = 1'b0;
  logic [ABW-1:0] t_adr = '0;
  logic [BEW-1:0] t_ben = '0;
  logic [DBW-1:0] t_wdt = '0;
  logic           t_rdy = 1'b0;
  logic [DBW-1:0] t_rdt = '0;
  logic           t_err = 1'b0;

  tcb_lib_register_response_if #(.ABW(ABW), .DBW(DBW), .SLW(SLW)) s1 ();
  tcb_lib_register_response_if #(.ABW(ABW), .DBW(DBW), .SLW(SLW)) m1 ();
  tcb_lib_register_response_if #(.ABW(ABW), .DBW(DBW), .SLW(SLW)) s2 ();
  tcb_lib_register_response_if #(.ABW(ABW), .DBW(DBW), .SLW(SLW)) m2 ();

  assign s1.vld = t_vld;  assign s2.vld = t_vld;
  assign s1.wen = t_wen;  assign s2.wen = t_wen;
  assign s1.adr = t_adr;  assign s2.adr = t_adr;
  assign s1.ben = t_ben;  assign s2.ben = t_ben;
  assign s1.wdt = t_wdt;  assign s2.wdt = t_wdt;
  assign m1.rdy = t_rdy;  assign m2.rdy = t_rdy;
  assign m1.rdt = t_rdt;  assign m2.rdt = t_rdt;
  assign m1.err = t_err;  assign m2.err = t_err;

  tcb_lib_register_response #(
    .ABW(ABW), .DBW(DBW), .SLW(SLW), .BEW(BEW), .DLY(DLY), .GRN(1)
  ) dut_g1 (
    .clk (clk),
    .rst (rst),
    .sub (s1),
    .man (m1)
  );

  tcb_lib_register_response #(
    .ABW(ABW), .DBW(DBW), .SLW(SLW), .BEW(BEW), .DLY(DLY), .GRN(2)
  ) dut_g2 (
    .clk (clk),
    .rst (rst),
    .sub (s2),
    .man (m2)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0]    due;
    logic           wen;
    logic [BEW-1:0] ben;
  } pend_t;

  pend_t          exp_q[$];
  logic [DBW-1:0] exp_rdt1 = '0;
  logic [DBW-1:0] exp_rdt2 = '0;
  logic           exp_err  = 1'b0;
  int             cyc      = 0;
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Byte b takes new data if any enable in its GRN-byte group was set
  function automatic logic [DBW-1:0] merge(input logic [DBW-1:0] old_d,
                                           input logic [DBW-1:0] new_d,
                                           input logic [BEW-1:0] ben,
                                           input int grn);
    logic [DBW-1:0] r;
    int             s;
    logic           hit;
    r = old_d;
    for (int b = 0; b < BEW; b++) begin
      s   = (b / grn) * grn;
      hit = 1'b0;
      for (int j = 0; j < grn; j++) hit = hit | ben[s+j];
      if (hit) r[8*b +: 8] = new_d[8*b +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_rdt1 = '0;
    exp_rdt2 = '0;
    exp_err  = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic vld, input logic wen, input logic [ABW-1:0] adr,
                       input logic [BEW-1:0] ben, input logic [DBW-1:0] wdt,
                       input logic rdy, input logic [DBW-1:0] rdt, input logic err);
    t_vld = vld; t_wen = wen; t_adr = adr; t_ben = ben; t_wdt = wdt;
    t_rdy = rdy; t_rdt = rdt; t_err = err;
    #1;
    check("req_path_g1", 128'({m1.vld, m1.wen, m1.adr, m1.ben, m1.wdt, s1.rdy}),
                         128'({vld, wen, adr, ben, wdt, rdy}));
    check("req_path_g2", 128'({m2.vld, m2.wen, m2.adr, m2.ben, m2.wdt, s2.rdy}),
                         128'({vld, wen, adr, ben, wdt, rdy}));
  endtask

  task automatic idle(input logic [DBW-1:0] rdt, input logic err);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, rdt, err);
  endtask

  task automatic check_rsp();
    check("rdt_g1", 128'(s1.rdt), 128'(exp_rdt1));
    check("err_g1", 128'(s1.err), 128'(exp_err));
    check("rdt_g2", 128'(s2.rdt), 128'(exp_rdt2));
    check("err_g2", 128'(s2.err), 128'(exp_err));
  endtask

  // One clock edge: log the handshake, retire the response that is due now,
  // then compare the registered outputs just after the edge.
  task automatic tick();
    pend_t p;
    @(posedge clk);
    if (rst) begin
      if (t_vld && t_rdy) begin
        p.due = 32'(cyc + DLY);
        p.wen = t_wen;
        p.ben = t_ben;
        exp_q.push_back(p);
      end
      if (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
        p = exp_q.pop_front();
        exp_err = t_err;
        if (!p.wen) begin
          exp_rdt1 = merge(exp_rdt1, t_rdt, p.ben, 1);
          exp_rdt2 = merge(exp_rdt2, t_rdt, p.ben, 2);
        end
      end
    end
    cyc++;
    #1;
    check_rsp();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle(32'hCAFEF00D, 1'b1);
    #3;
    check_rsp();
    tick();
    tick();
    #2 rst = 1'b1;
    tick();

    // write: no read-data change, err from the response cycle
    drive(1'b1, 1'b1, 32'h10, 4'hF, 32'h01234567, 1'b1, 32'hFFFFFFFF, 1'b1);
    tick();
    idle(32'hDEADBEEF, 1'b0);
    tick();
    check("write_rdt_hold", 128'(s1.rdt), 128'(32'h0));
    check("write_err", 128'(s1.err), 128'(1'b0));

    // full read, then hold
    drive(1'b1, 1'b0, 32'h10, 4'hF, '0, 1'b1, 32'hBADBAD00, 1'b1);
    tick();
    idle(32'h01234567, 1'b0);
    tick();
    check("read_rdt", 128'(s1.rdt), 128'(32'h01234567));
    idle(32'h76543210, 1'b1);
    tick();
    check("read_hold", 128'(s1.rdt), 128'(32'h01234567));

    // partial read, byte 0 only
    drive(1'b1, 1'b0, 32'h10, 4'h1, '0, 1'b1, 32'h0, 1'b0);
    tick();
    idle(32'hAABBCCDD, 1'b0);
    tick();
    check("partial_g1", 128'(s1.rdt), 128'(32'h012345DD));
    check("partial_g2", 128'(s2.rdt), 128'(32'h0123CCDD));

    // stall for three cycles, then accept
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h20, 4'hF, '0, 1'b0, $urandom, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 32'h20, 4'hF, '0, 1'b1, 32'h13579BDF, 1'b1);
    tick();
    check("stall_no_upd", 128'(s1.rdt), 128'(32'h012345DD));
    idle(32'h5A5A5A5A, 1'b0);
    tick();
    check("stall_upd", 128'(s1.rdt), 128'(32'h5A5A5A5A));
    idle(32'h0F0F0F0F, 1'b1);
    tick();

    // back-to-back reads
    drive(1'b1, 1'b0, 32'h30, 4'hF, '0, 1'b1, 32'h99999999, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h34, 4'hF, '0, 1'b1, 32'h11111111, 1'b0);
    tick();
    check("b2b_rdt0", 128'(s1.rdt), 128'(32'h11111111));
    check("b2b_err0", 128'(s1.err), 128'(1'b0));
    idle(32'h22222222, 1'b1);
    tick();
    check("b2b_rdt1", 128'(s1.rdt), 128'(32'h22222222));
    check("b2b_err1", 128'(s1.err), 128'(1'b1));

    // asynchronous reset with a read in flight
    drive(1'b1, 1'b0, 32'h40, 4'hF, '0, 1'b1, 32'h0, 1'b0);
    tick();
    idle(32'h33333333, 1'b1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_rdt", 128'(s1.rdt), 128'(32'h0));
    check("async_rst_err", 128'(s1.err), 128'(1'b0));
    check_rsp();
    tick();
    idle(32'h44444444, 1'b1);
    #2 rst = 1'b1;
    tick();
    idle(32'h55555555, 1'b1);
    tick();
    check("no_upd_after_rst", 128'(s2.rdt), 128'(32'h0));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
            BEW'($urandom), $urandom, $urandom_range(0, 4) != 0,
            $urandom, $urandom_range(0, 1) == 1);
      tick();
    end
    idle($urandom, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
